// File: rtl/edm_tx_mux.sv
// TX block mux: gates monitor read strobes with a periodic forced-idle window and registers
// the selected 66b block toward the PCS. Optional per-source counters under EDM_TX_STATS_EN.
module edm_tx_mux #(
  parameter int IDLE_INTERVAL = 1024,
  parameter int IDLE_COUNT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sel,
  input  logic        memq_read_in,
  input  logic        reqq_read_in,
  input  logic        netq_read_in,
  output logic        memq_rd,
  output logic        reqq_rd,
  output logic        netq_rd,
  input  logic [65:0] memq_dout,
  input  logic [65:0] reqq_dout,
  input  logic [65:0] netq_dout,
  output logic [1:0]  tx_header,
  output logic [63:0] tx_data,
  output logic        tx_valid,
  output logic [15:0] bad_hdr_cnt,
  output logic [31:0] stat_mem,
  output logic [31:0] stat_req,
  output logic [31:0] stat_net,
  output logic [31:0] stat_idle
);
  localparam int          CW        = $clog2(IDLE_INTERVAL);
  localparam logic [1:0]  IDLE_HDR  = 2'b01;
  localparam logic [63:0] IDLE_DATA = 64'h0000_0000_0000_001E;

  typedef enum logic {PASS, FORCE_IDLE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          hold;

  // One counter serves both phases: output cycles in PASS, idle blocks in FORCE_IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      PASS: if (cnt == CW'(IDLE_INTERVAL - 1)) begin
        state_nxt = FORCE_IDLE;
        cnt_nxt   = '0;
      end
      FORCE_IDLE: if (cnt == CW'(IDLE_COUNT - 1)) begin
        state_nxt = PASS;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = PASS;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PASS;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign hold    = (state == FORCE_IDLE);
  assign memq_rd = memq_read_in & ~hold & ~reset;
  assign reqq_rd = reqq_read_in & ~hold & ~reset;
  assign netq_rd = netq_read_in & ~hold & ~reset;

  logic        sel_vld, hdr_ok, emit, bad;
  logic [65:0] sel_blk;

  // A block is taken only when sel and the matching read request agree.
  always_comb begin
    sel_vld = 1'b0;
    sel_blk = '0;
    case (sel)
      2'b01: begin sel_vld = reqq_read_in; sel_blk = reqq_dout; end
      2'b10: begin sel_vld = memq_read_in; sel_blk = memq_dout; end
      2'b11: begin sel_vld = netq_read_in; sel_blk = netq_dout; end
      default: ;
    endcase
    if (hold) sel_vld = 1'b0;
  end

  assign hdr_ok = (sel_blk[65:64] == 2'b10) || (sel_blk[65:64] == 2'b01);
  assign emit   = sel_vld & hdr_ok;
  assign bad    = sel_vld & ~hdr_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_header   <= IDLE_HDR;
      tx_data     <= IDLE_DATA;
      tx_valid    <= 1'b0;
      bad_hdr_cnt <= '0;
    end else begin
      tx_valid  <= 1'b1;
      tx_header <= emit ? sel_blk[65:64] : IDLE_HDR;
      tx_data   <= emit ? sel_blk[63:0]  : IDLE_DATA;
      if (bad && bad_hdr_cnt != 16'hFFFF) bad_hdr_cnt <= bad_hdr_cnt + 16'd1;
    end
  end

`ifdef EDM_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_mem  <= '0;
      stat_req  <= '0;
      stat_net  <= '0;
      stat_idle <= '0;
    end else if (!emit) begin
      if (stat_idle != '1) stat_idle <= stat_idle + 32'd1;
    end else begin
      case (sel)
        2'b01:   if (stat_req != '1) stat_req <= stat_req + 32'd1;
        2'b10:   if (stat_mem != '1) stat_mem <= stat_mem + 32'd1;
        default: if (stat_net != '1) stat_net <= stat_net + 32'd1;
      endcase
    end
  end
`else
  assign stat_mem  = '0;
  assign stat_req  = '0;
  assign stat_net  = '0;
  assign stat_idle = '0;
`endif

endmodule

// File: tb/tb_edm_tx_mux.sv
// Randomized bench for edm_tx_mux: FIFO arrays + cycle-index model of the idle window.
`timescale 1ns/1ps
module tb_edm_tx_mux;
  localparam int INT    = 8;
  localparam int ICNT   = 2;
  localparam int PERIOD = INT + ICNT;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic        memq_read_in, reqq_read_in, netq_read_in;
  logic        memq_rd, reqq_rd, netq_rd;
  logic [65:0] memq_dout, reqq_dout, netq_dout;
  logic [1:0]  tx_header;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic [15:0] bad_hdr_cnt;
  logic [31:0] stat_mem, stat_req, stat_net, stat_idle;

  always #5 clk = ~clk;

  edm_tx_mux #(.IDLE_INTERVAL(INT), .IDLE_COUNT(ICNT)) dut (
    .clk(clk), .reset(reset), .sel(sel),
    .memq_read_in(memq_read_in), .reqq_read_in(reqq_read_in), .netq_read_in(netq_read_in),
    .memq_rd(memq_rd), .reqq_rd(reqq_rd), .netq_rd(netq_rd),
    .memq_dout(memq_dout), .reqq_dout(reqq_dout), .netq_dout(netq_dout),
    .tx_header(tx_header), .tx_data(tx_data), .tx_valid(tx_valid),
    .bad_hdr_cnt(bad_hdr_cnt),
    .stat_mem(stat_mem), .stat_req(stat_req), .stat_net(stat_net), .stat_idle(stat_idle)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Queue contents indexed by source: 0 req, 1 mem, 2 net (sel code minus one).
  logic [65:0] fifo [3][1024];
  int          ptr [3];
  int          cyc;
  int          m_bad, m_mem, m_req, m_net, m_idle;
`ifdef EDM_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  function automatic logic [65:0] rand_blk();
    logic [1:0] h;
    h = ($urandom_range(0, 15) == 0) ? (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00)
                                     : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
    return {h, $urandom(), $urandom()};
  endfunction

  // One clock: drive, check strobes, predict, then check the registered outputs.
  task automatic step(input logic rst, input logic [1:0] s, input logic [2:0] rin);
    logic       hold;
    logic [2:0] erd;
    logic [1:0] eh;
    logic [63:0] ed;
    logic [65:0] blk;
    reset        = rst;
    sel          = s;
    reqq_read_in = rin[0];
    memq_read_in = rin[1];
    netq_read_in = rin[2];
    reqq_dout    = fifo[0][ptr[0] % 1024];
    memq_dout    = fifo[1][ptr[1] % 1024];
    netq_dout    = fifo[2][ptr[2] % 1024];
    #1;
    hold = !rst && ((cyc % PERIOD) >= INT);
    erd  = (rst || hold) ? 3'b000 : rin;
    chk("rd_strobes", {61'd0, netq_rd, memq_rd, reqq_rd}, {61'd0, erd});
    eh = 2'b01;
    ed = 64'h1E;
    if (rst) begin
      cyc = 0; m_bad = 0; m_mem = 0; m_req = 0; m_net = 0; m_idle = 0;
    end else begin
      if (!hold && s != 2'b00 && rin[s - 2'd1]) begin
        blk = fifo[s - 2'd1][ptr[s - 2'd1] % 1024];
        if (blk[65:64] == 2'b10 || blk[65:64] == 2'b01) begin
          eh = blk[65:64];
          ed = blk[63:0];
          if (s == 2'b01) m_req++; else if (s == 2'b10) m_mem++; else m_net++;
        end else begin
          if (m_bad < 65535) m_bad++;
          m_idle++;
        end
      end else m_idle++;
      for (int i = 0; i < 3; i++) if (erd[i]) ptr[i]++;
      cyc++;
    end
    @(posedge clk);
    #1;
    chk("tx_valid", {63'd0, tx_valid}, {63'd0, !rst});
    chk("tx_header", {62'd0, tx_header}, {62'd0, eh});
    chk("tx_data", tx_data, ed);
    chk("bad_hdr_cnt", {48'd0, bad_hdr_cnt}, 64'(m_bad));
    @(negedge clk);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_mem"},  {32'd0, stat_mem},  STATS ? 64'(m_mem)  : 64'd0);
    chk({tag, "_req"},  {32'd0, stat_req},  STATS ? 64'(m_req)  : 64'd0);
    chk({tag, "_net"},  {32'd0, stat_net},  STATS ? 64'(m_net)  : 64'd0);
    chk({tag, "_idle"}, {32'd0, stat_idle}, STATS ? 64'(m_idle) : 64'd0);
  endtask

  initial begin
    logic [1:0] s;
    logic [2:0] r;
    for (int q = 0; q < 3; q++) begin
      ptr[q] = 0;
      for (int i = 0; i < 1024; i++) fifo[q][i] = rand_blk();
    end
    cyc = 0;
    m_bad = 0; m_mem = 0; m_req = 0; m_net = 0; m_idle = 0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 3'b000);
    chk_stats("rst_stats");
    step(1'b0, 2'b00, 3'b000);

    fifo[1][ptr[1] % 1024] = {2'b10, 64'hDEADBEEF_00000001};
    step(1'b0, 2'b10, 3'b010);

    fifo[0][ptr[0] % 1024] = {2'b11, 64'h1234};
    step(1'b0, 2'b01, 3'b001);

    // Net queue streaming across the forced-idle window.
    for (int i = 0; i < 2 * PERIOD; i++) step(1'b0, 2'b11, 3'b100);

    // Selected-but-not-requested inconsistency.
    step(1'b0, 2'b10, 3'b000);

    for (int i = 0; i < 400; i++) begin
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) r = 3'($urandom_range(0, 7));
      else r = (s == 2'b00) ? 3'b000 : (3'b001 << (s - 2'd1));
      step(1'b0, s, r);
    end
    chk_stats("rand_stats");

    // Reset landing inside a forced-idle window.
    for (int i = 0; i < PERIOD && (cyc % PERIOD) != INT; i++) step(1'b0, 2'b11, 3'b100);
    step(1'b1, 2'b11, 3'b100);
    chk_stats("midwin_stats");
    for (int i = 0; i < 5; i++) step(1'b0, 2'b11, 3'b100);

    // 5 mem, 3 req, 2 none from reset.
    step(1'b1, 2'b00, 3'b000);
    for (int q = 0; q < 2; q++)
      for (int i = 0; i < 8; i++) fifo[q][(ptr[q] + i) % 1024][65:64] = 2'b10;
    for (int i = 0; i < 5; i++) step(1'b0, 2'b10, 3'b010);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b01, 3'b001);
    for (int i = 0; i < 2; i++) step(1'b0, 2'b00, 3'b000);
    chk_stats("dir_stats");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
